// File: rtl/gsau_wb_buffer.sv
// gsau_wb_buffer: writeback FIFO between the GSAU psum output channel and the
// veggie vector register file write port. Each drained entry raises a
// scoreboard clear for its destination register in the same cycle it commits.
// Optional build macro GSAU_WB_BUF_PERF_EN adds stall/peak-occupancy counters.
module gsau_wb_buffer #(
    parameter int unsigned VREG_W = 512,
    parameter int unsigned VSEL_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [VREG_W-1:0]        wb_psum,
    input  logic [VSEL_W-1:0]        wb_wbdst,
    input  logic                     wb_valid,
    output logic                     wb_output_ready,
    input  logic                     flush,
    output logic                     vwr_en,
    output logic [VSEL_W-1:0]        vwr_sel,
    output logic [VREG_W-1:0]        vwr_data,
    input  logic                     vwr_ready,
    output logic                     sb_clr_valid,
    output logic [VSEL_W-1:0]        sb_clr_vdst,
    output logic [$clog2(DEPTH):0]   count
`ifdef GSAU_WB_BUF_PERF_EN
    ,
    output logic [31:0]              perf_stall_cycles,
    output logic [31:0]              perf_drain_stall,
    output logic [$clog2(DEPTH):0]   perf_max_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [VREG_W-1:0] data_mem [DEPTH];
    logic [VSEL_W-1:0] dst_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             enq, deq;

    // Outputs come only from registered state, except the clear strobe.
    assign wb_output_ready = (count_q < FULL_CNT);
    assign vwr_en          = (count_q != '0);
    assign vwr_sel         = dst_mem[rd_ptr_q];
    assign vwr_data        = data_mem[rd_ptr_q];
    assign sb_clr_vdst     = vwr_sel;
    assign count           = count_q;

    // Flush kills both handshakes so nothing commits and no clear is issued.
    assign enq          = wb_valid & wb_output_ready & ~flush;
    assign deq          = vwr_en & vwr_ready & ~flush;
    assign sb_clr_valid = deq;

    // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            data_mem[wr_ptr_q] <= wb_psum;
            dst_mem[wr_ptr_q]  <= wb_wbdst;
        end
    end

`ifdef GSAU_WB_BUF_PERF_EN
    logic [31:0]      stall_q;
    logic [31:0]      drain_q;
    logic [CNT_W-1:0] max_q;

    // Performance counters; cleared by reset only, flush leaves them intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            drain_q <= '0;
            max_q   <= '0;
        end else begin
            if (wb_valid && !wb_output_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
            if (vwr_en && !vwr_ready && (drain_q != '1))         drain_q <= drain_q + 32'd1;
            if (count_d > max_q)                                  max_q   <= count_d;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_drain_stall  = drain_q;
    assign perf_max_count    = max_q;
`endif

endmodule

// File: tb/tb_gsau_wb_buffer.sv
// Directed self-checking bench for gsau_wb_buffer (default build, DEPTH=4).
module tb_gsau_wb_buffer;

    localparam int VREG_W = 512;
    localparam int VSEL_W = 5;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [VREG_W-1:0] wb_psum;
    logic [VSEL_W-1:0] wb_wbdst;
    logic              wb_valid;
    logic              wb_output_ready;
    logic              flush;
    logic              vwr_en;
    logic [VSEL_W-1:0] vwr_sel;
    logic [VREG_W-1:0] vwr_data;
    logic              vwr_ready;
    logic              sb_clr_valid;
    logic [VSEL_W-1:0] sb_clr_vdst;
    logic [2:0]        count;

    int n_checks = 0;
    int n_fail   = 0;

    gsau_wb_buffer #(
        .VREG_W(VREG_W),
        .VSEL_W(VSEL_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_psum        (wb_psum),
        .wb_wbdst       (wb_wbdst),
        .wb_valid       (wb_valid),
        .wb_output_ready(wb_output_ready),
        .flush          (flush),
        .vwr_en         (vwr_en),
        .vwr_sel        (vwr_sel),
        .vwr_data       (vwr_data),
        .vwr_ready      (vwr_ready),
        .sb_clr_valid   (sb_clr_valid),
        .sb_clr_vdst    (sb_clr_vdst),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are changed 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one entry with vwr_ready held at the given value.
    task automatic push(input logic [VSEL_W-1:0] d, input logic vr);
        wb_valid  = 1'b1;
        wb_wbdst  = d;
        wb_psum   = {64{3'b0, d}};
        vwr_ready = vr;
        step();
        wb_valid  = 1'b0;
    endtask

    logic [VREG_W-1:0] pat_a5;
    logic [VREG_W-1:0] pat_12;
    logic [4:0]        d12;

    initial begin
        int model_cnt;
        int in_idx;
        int out_idx;
        int cyc;
        logic acc;
        logic dq;

        pat_a5    = {64{8'hA5}};
        d12       = 5'd12;
        pat_12    = {64{3'b0, d12}};
        rst       = 1'b1;
        wb_psum   = '0;
        wb_wbdst  = '0;
        wb_valid  = 1'b0;
        flush     = 1'b0;
        vwr_ready = 1'b0;
        step();
        step();

        // Reset state
        check_eq("rst_count", count, 0);
        check_eq("rst_ready", wb_output_ready, 1);
        check_eq("rst_vwr_en", vwr_en, 0);
        check_eq("rst_sb_clr", sb_clr_valid, 0);
        rst = 1'b0;
        step();

        // Single pass-through
        wb_valid  = 1'b1;
        wb_psum   = pat_a5;
        wb_wbdst  = 5'd7;
        vwr_ready = 1'b1;
        #1;
        check_eq("pt_empty_en", vwr_en, 0);
        check_eq("pt_empty_clr", sb_clr_valid, 0);
        step();
        wb_valid = 1'b0;
        #1;
        check_eq("pt_en", vwr_en, 1);
        check_eq("pt_sel", vwr_sel, 7);
        check_eq("pt_data", vwr_data, pat_a5);
        check_eq("pt_clr", sb_clr_valid, 1);
        check_eq("pt_clr_vdst", sb_clr_vdst, 7);
        check_eq("pt_count1", count, 1);
        step();
        check_eq("pt_count0", count, 0);
        check_eq("pt_en0", vwr_en, 0);

        // Fill to full
        for (int d = 1; d <= 4; d++) push(5'(d), 1'b0);
        wb_valid = 1'b1;
        wb_wbdst = 5'd5;
        #1;
        check_eq("full_count", count, 4);
        check_eq("full_ready", wb_output_ready, 0);
        check_eq("full_clr_no_grant", sb_clr_valid, 0);
        step();
        check_eq("full_no_accept", count, 4);
        wb_valid  = 1'b0;
        vwr_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check_eq($sformatf("drain_sel%0d", i), vwr_sel, i);
            check_eq($sformatf("drain_clr%0d", i), sb_clr_valid, 1);
            check_eq($sformatf("drain_ready%0d", i), wb_output_ready, (i == 1) ? 0 : 1);
            step();
        end
        check_eq("drain_count0", count, 0);
        vwr_ready = 1'b0;

        // Pointer wrap: 10 pushes, vwr_ready toggling, producer holds until accepted
        model_cnt = 0;
        in_idx    = 0;
        out_idx   = 0;
        cyc       = 0;
        while (out_idx < 10 && cyc < 60) begin
            wb_valid  = (in_idx < 10);
            wb_wbdst  = 5'(in_idx);
            wb_psum   = '0;
            vwr_ready = cyc[0] ? 1'b0 : 1'b1;
            #1;
            check_eq("wrap_count", count, model_cnt);
            check_eq("wrap_ready", wb_output_ready, (model_cnt < 4) ? 1 : 0);
            acc = wb_valid && (model_cnt < 4);
            dq  = (model_cnt > 0) && vwr_ready;
            if (dq) check_eq("wrap_order", vwr_sel, out_idx);
            if (acc) in_idx++;
            if (dq) out_idx++;
            model_cnt = model_cnt + (acc ? 1 : 0) - (dq ? 1 : 0);
            cyc++;
            step();
        end
        check_eq("wrap_all_out", out_idx, 10);
        check_eq("wrap_end_count", count, 0);
        wb_valid  = 1'b0;
        vwr_ready = 1'b0;

        // Simultaneous push/pop at count=2
        push(5'd10, 1'b0);
        push(5'd11, 1'b0);
        wb_valid  = 1'b1;
        wb_wbdst  = 5'd12;
        wb_psum   = pat_12;
        vwr_ready = 1'b1;
        #1;
        check_eq("sim_count_pre", count, 2);
        check_eq("sim_head", vwr_sel, 10);
        check_eq("sim_clr", sb_clr_valid, 1);
        step();
        wb_valid  = 1'b0;
        vwr_ready = 1'b0;
        #1;
        check_eq("sim_count_post", count, 2);
        check_eq("sim_head_adv", vwr_sel, 11);
        vwr_ready = 1'b1;
        step();
        check_eq("sim_tail_sel", vwr_sel, 12);
        check_eq("sim_tail_data", vwr_data, pat_12);
        step();
        check_eq("sim_empty", count, 0);
        vwr_ready = 1'b0;

        // Flush with concurrent push and grant at count=3
        push(5'd20, 1'b0);
        push(5'd21, 1'b0);
        push(5'd22, 1'b0);
        flush     = 1'b1;
        wb_valid  = 1'b1;
        wb_wbdst  = 5'd23;
        vwr_ready = 1'b1;
        #1;
        check_eq("fl_count_pre", count, 3);
        check_eq("fl_clr_forced0", sb_clr_valid, 0);
        step();
        flush    = 1'b0;
        wb_valid = 1'b0;
        #1;
        check_eq("fl_count", count, 0);
        check_eq("fl_vwr_en", vwr_en, 0);
        check_eq("fl_clr", sb_clr_valid, 0);
        step();
        check_eq("fl_push_absent", count, 0);
        vwr_ready = 1'b0;

        // Async reset mid-drain
        push(5'd1, 1'b0);
        push(5'd2, 1'b0);
        push(5'd3, 1'b0);
        check_eq("ar_count_pre", count, 3);
        vwr_ready = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check_eq("ar_vwr_en", vwr_en, 0);
        check_eq("ar_ready", wb_output_ready, 1);
        check_eq("ar_count", count, 0);
        #1;
        rst = 1'b0;
        step();
        push(5'd9, 1'b1);
        #1;
        check_eq("ar_sole_en", vwr_en, 1);
        check_eq("ar_sole_sel", vwr_sel, 9);
        check_eq("ar_sole_count", count, 1);
        step();
        check_eq("ar_done_count", count, 0);
        check_eq("ar_done_en", vwr_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
